// File: rtl/alu_issue_if.sv
// Request and result channels of the ALU issue/retire stage.
// Optional flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic [2:0]       in_opsel;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
`ifdef ALU_FLAGS_EN
  logic             out_z_flag;
  logic             out_s_flag;
`endif

  // Upstream producer / writeback consumer side
  modport master (
    output in_valid, in_op1, in_op2, in_opsel, in_mode, out_ready,
`ifdef ALU_FLAGS_EN
    input  out_z_flag, out_s_flag,
`endif
    input  in_ready, out_valid, out_result
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_op1, in_op2, in_opsel, in_mode, out_ready,
`ifdef ALU_FLAGS_EN
    output out_z_flag, out_s_flag,
`endif
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue and retire stage around a combinational ALU.
// Requests are buffered in a DEPTH-entry FIFO, issued from a register (S1)
// onto the alu_* ports, and the ALU result is captured in an output
// register (S2) with a valid/ready handshake toward writeback.
// Optional feature macro: ALU_FLAGS_EN adds registered zero/sign flags.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_issue_if.slave                 bus,
  output logic [WIDTH-1:0]           alu_op1,
  output logic [WIDTH-1:0]           alu_op2,
  output logic [2:0]                 alu_opsel,
  output logic                       alu_mode,
  input  logic [WIDTH-1:0]           alu_result,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       opsel;
    logic             mode;
  } req_t;

  req_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  req_t             req_p1;
  logic             vld_p1;
  logic signed [WIDTH-1:0] res_p2;
  logic             vld_p2;
`ifdef ALU_FLAGS_EN
  logic             z_p2;
  logic             s_p2;
`endif

  logic push;
  logic s2_adv;
  logic s1_load;

  // Ready depends only on registered occupancy; nothing is taken during reset
  assign bus.in_ready = rst_n && (count < DEPTH_C);
  assign push         = bus.in_valid && bus.in_ready;
  assign s2_adv       = !vld_p2 || bus.out_ready;
  assign s1_load      = (count != '0) && (!vld_p1 || s2_adv);

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (s1_load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, s1_load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; entries are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_op1, bus.in_op2, bus.in_opsel, bus.in_mode};
  end

  // ---- Stage boundary p1: issue register feeding the ALU ----
  // Operands hold their last value when the stage stalls or empties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      req_p1 <= '0;
    end else if (s1_load) begin
      vld_p1 <= 1'b1;
      req_p1 <= mem[rd_ptr];
    end else if (s2_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  assign alu_op1   = req_p1.op1;
  assign alu_op2   = req_p1.op2;
  assign alu_opsel = req_p1.opsel;
  assign alu_mode  = req_p1.mode;

  // ---- Stage boundary p2: result register toward writeback ----
  // Result and flags are held while the consumer back-pressures
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
`ifdef ALU_FLAGS_EN
      z_p2   <= 1'b0;
      s_p2   <= 1'b0;
`endif
    end else if (vld_p1 && s2_adv) begin
      vld_p2 <= 1'b1;
      res_p2 <= alu_result;
`ifdef ALU_FLAGS_EN
      z_p2   <= (alu_result == '0);
      s_p2   <= alu_result[WIDTH-1];
`endif
    end else if (bus.out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign bus.out_valid  = vld_p2;
  assign bus.out_result = res_p2;
`ifdef ALU_FLAGS_EN
  assign bus.out_z_flag = z_p2;
  assign bus.out_s_flag = s_p2;
`endif
  assign fifo_count     = count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized bench for alu_issue_stage with an adder ALU stub.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0]           alu_op1;
  logic [WIDTH-1:0]           alu_op2;
  logic [2:0]                 alu_opsel;
  logic                       alu_mode;
  logic [WIDTH-1:0]           alu_result;
  logic [$clog2(DEPTH):0]     fifo_count;

  assign alu_result = alu_op1 + alu_op2;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: expected sums in acceptance order, plus hold-under-stall check
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] sb_e;
  logic [WIDTH-1:0] held_res;
  logic             stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_result), 64'(held_res));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_result", 64'(exp_q.size()), 64'd1);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_data", 64'(bus.out_result), 64'(sb_e));
`ifdef ALU_FLAGS_EN
          check("sb_z", 64'(bus.out_z_flag), 64'(sb_e == '0));
          check("sb_s", 64'(bus.out_s_flag), 64'(sb_e[WIDTH-1]));
`endif
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_res   = bus.out_result;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_op1 + bus.in_op2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.in_valid  = 1'b1;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
  endtask

  int n_acc;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.in_opsel  = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_alu_op1", 64'(alu_op1), 64'd0);
    check("rst_alu_op2", 64'(alu_op2), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single request: latency and pass-through of opsel/mode
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op1    = 32'd5;
    bus.in_op2    = 32'd7;
    bus.in_opsel  = 3'd5;
    bus.in_mode   = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t1_e0_valid", 64'(bus.out_valid), 64'd0);
    check("t1_e0_count", 64'(fifo_count), 64'd1);
    step();
    check("t1_e1_valid", 64'(bus.out_valid), 64'd0);
    check("t1_e1_count", 64'(fifo_count), 64'd0);
    check("t1_alu_op1", 64'(alu_op1), 64'd5);
    check("t1_alu_op2", 64'(alu_op2), 64'd7);
    check("t1_alu_opsel", 64'(alu_opsel), 64'd5);
    check("t1_alu_mode", 64'(alu_mode), 64'd1);
    step();
    check("t1_e2_valid", 64'(bus.out_valid), 64'd1);
    check("t1_e2_result", 64'(bus.out_result), 64'd12);
    step();
    check("t1_e3_valid", 64'(bus.out_valid), 64'd0);
    check("t1_op1_held", 64'(alu_op1), 64'd5);

    // Back-to-back stream of 8 requests
    bus.in_opsel = 3'd0;
    bus.in_mode  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        check("t2_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_op1   = WIDTH'(c);
        bus.in_op2   = 32'd100;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (c >= 2) begin
        check("t2_valid", 64'(bus.out_valid), 64'd1);
        check("t2_result", 64'(bus.out_result), 64'(100 + c - 2));
      end
    end
    step();
    check("t2_end_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure: fill until in_ready drops, then drain
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int g = 0; g < 12; g++) begin
      if (!bus.in_ready) break;
      bus.in_valid = 1'b1;
      bus.in_op1   = WIDTH'(n_acc + 1);
      bus.in_op2   = 32'd1000;
      step();
      n_acc++;
    end
    bus.in_valid = 1'b0;
    check("t3_accepted", 64'(n_acc), 64'd6);
    check("t3_count_full", 64'(fifo_count), 64'd4);
    check("t3_in_ready", 64'(bus.in_ready), 64'd0);
    check("t3_valid", 64'(bus.out_valid), 64'd1);
    check("t3_first", 64'(bus.out_result), 64'd1001);
    step();
    check("t3_frozen", 64'(bus.out_result), 64'd1001);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      step();
      check("t3_drain_valid", 64'(bus.out_valid), 64'd1);
      check("t3_drain_result", 64'(bus.out_result), 64'(1001 + k));
    end
    step();
    check("t3_drain_end", 64'(bus.out_valid), 64'd0);
    check("t3_drain_count", 64'(fifo_count), 64'd0);

    // Wraparound and sign boundary
    issue_one(32'hFFFF_FFFF, 32'd1);
    check("t4_wrap_valid", 64'(bus.out_valid), 64'd1);
    check("t4_wrap_result", 64'(bus.out_result), 64'd0);
`ifdef ALU_FLAGS_EN
    check("t4_wrap_z", 64'(bus.out_z_flag), 64'd1);
    check("t4_wrap_s", 64'(bus.out_s_flag), 64'd0);
`endif
    step();
    issue_one(32'h7FFF_FFFF, 32'd1);
    check("t4_sign_valid", 64'(bus.out_valid), 64'd1);
    check("t4_sign_result", 64'(bus.out_result), 64'h8000_0000);
`ifdef ALU_FLAGS_EN
    check("t4_sign_z", 64'(bus.out_z_flag), 64'd0);
    check("t4_sign_s", 64'(bus.out_s_flag), 64'd1);
`endif
    step();

    // Reset with three requests in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op1   = WIDTH'(50 + i);
      bus.in_op2   = 32'd0;
      step();
    end
    bus.in_valid = 1'b0;
    check("t5_pre_valid", 64'(bus.out_valid), 64'd1);
    check("t5_pre_count", 64'(fifo_count), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_count", 64'(fifo_count), 64'd0);
    check("t5_result", 64'(bus.out_result), 64'd0);
    check("t5_alu_op1", 64'(alu_op1), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_stale", 64'(bus.out_valid), 64'd0);
    end

    // Random handshake toggling against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_op1    = $urandom;
      bus.in_op2    = $urandom;
      bus.in_opsel  = 3'($urandom_range(0, 7));
      bus.in_mode   = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) step();
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    check("t6_count", 64'(fifo_count), 64'd0);
    check("t6_valid", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue and retire stage wrapped around the combinational 32-bit ALU.
- Buffers incoming operation requests {op1, op2, opsel, mode} in a small FIFO and drives them one per cycle from a register onto the ALU inputs.
- Captures the ALU result into an output register with a valid/ready handshake toward the writeback consumer.
- Decouples the ALU from upstream and downstream stalls without breaking its single-cycle combinational path.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU.
- DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted.
- in_op1  in  WIDTH  operand 1.
- in_op2  in  WIDTH  operand 2.
- in_opsel  in  3  operation select, passed through unmodified.
- in_mode  in  1  arithmetic/logic mode, passed through unmodified.
- alu_op1  out  WIDTH  registered operand 1 to the ALU.
- alu_op2  out  WIDTH  registered operand 2 to the ALU.
- alu_opsel  out  3  registered opsel to the ALU.
- alu_mode  out  1  registered mode to the ALU.
- alu_result  in  WIDTH  combinational result from the ALU.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  registered result.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clk edge): FIFO count and pointers 0; S1 and S2 valid 0; alu_op1, alu_op2, alu_opsel, alu_mode, out_result all 0; out_valid 0.
- Reset mid-operation drops all in-flight requests, with no partial output. No request is accepted in a reset cycle.
- Three storage points:
  - FIFO (DEPTH entries).
  - S1: the issue register driving the alu_* ports.
  - S2: the output register.
- Push: occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH), from registered count only; no same-cycle pop pass-through.
  - At full, in_ready is 0 even if a pop occurs that cycle.
- S1 advance condition: s2_adv = !S2_valid || out_ready.
- S1 load condition: s1_load = count > 0 && (!S1_valid || s2_adv).
  - On s1_load, the FIFO head is popped into S1 and S1_valid becomes 1.
  - If S1 advances with no FIFO data, S1_valid becomes 0.
- S2 load: on S1_valid && s2_adv, alu_result is captured into out_result and out_valid becomes 1.
  - If out_ready && !S1_valid, out_valid becomes 0.
- alu_* ports hold their last value while S1 is stalled or invalid; they never glitch to 0 outside reset.
- Simultaneous push and pop: count unchanged. Push when empty: no pop that cycle; there is no bypass.
- Latency: request accepted at edge t → in S1 after edge t+1 → out_valid high after edge t+2, i.e. 3 cycles from the in_valid cycle.
- Throughput is 1 result per cycle when out_ready is held high.
- out_result is stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Results retire strictly in acceptance order.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, adds outputs out_z_flag and out_s_flag (1 bit each), registered in S2 together with out_result:
  - out_z_flag = (alu_result == 0)
  - out_s_flag = alu_result[WIDTH-1]
  - Both reset to 0 and hold under backpressure.
- When undefined, both ports and their registers are absent and all other behaviour is identical.

Test Plan:
- Bench ALU stub alu_result = alu_op1 + alu_op2. Reset, then single request op1=5, op2=7 with out_ready=1 → out_valid exactly 3 cycles after in_valid, out_result=12, then out_valid drops.
- Stream of 8 back-to-back requests (op1=i, op2=100), out_ready=1 → 8 consecutive out_valid cycles with results 100..107 in order; in_ready stays 1 throughout.
- out_ready=0, push until in_ready=0 → accepts DEPTH+2=6 requests, fifo_count=4, out_result frozen at the first result; raising out_ready drains all 6 in order.
- Request op1=32'hFFFFFFFF, op2=1 → out_result=0 (wrap). With ALU_FLAGS_EN: out_z_flag=1, out_s_flag=0. For op1=32'h7FFFFFFF, op2=1: out_s_flag=1, out_z_flag=0.
- Assert rst_n low for 1 cycle while 3 requests are in flight → out_valid=0 and fifo_count=0 next cycle, and no stale result ever appears.
- Random in_valid/out_ready toggling over 1000 cycles against a scoreboard → in-order, lossless, no duplicate results, and out_result stable while stalled.
